apb_requester: RTL and testbench

APB requester (master) that turns a simple valid/ready command stream into single APB transfers toward an APB completer such as the 16-word register memory on the same bus. It sequences the SETUP and ACCESS phases and waits on PREADY. It returns read data and error status on a valid/ready response channel. A wait-state timeout keeps a hung completer from stalling the issuing logic.

---
 rtl/apb_requester.sv | 102 ++++++++++
 tb/tb_apb_requester.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/apb_requester.sv
// apb_requester: single-transfer APB requester driven by a valid/ready command stream
//   Parameters: ADDR_W address width, DATA_W data width (multiple of 8),
//               TIMEOUT max ACCESS cycles per transfer (0 = never time out)
//   Clock/reset: PCLK (rising edge), PRESETn (asynchronous, active low)
//   Command:     cmd_valid/cmd_ready handshake, cmd_write, cmd_addr, cmd_wdata, cmd_strb
//   Response:    rsp_valid/rsp_ready handshake, rsp_rdata, rsp_error, rsp_timeout
//   APB:         PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB out; PRDATA, PREADY, PERROR in
module apb_requester #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                PCLK,
    input  logic                PRESETn,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_strb,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_error,
    output logic                rsp_timeout,
    output logic                PSEL,
    output logic                PENABLE,
    output logic                PWRITE,
    output logic [ADDR_W-1:0]   PADDR,
    output logic [DATA_W-1:0]   PWDATA,
    output logic [DATA_W/8-1:0] PSTRB,
    input  logic [DATA_W-1:0]   PRDATA,
    input  logic                PREADY,
    input  logic                PERROR
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
    // Counter value on the last permitted ACCESS cycle; unused when TIMEOUT is 0
    localparam logic [15:0] LAST = 16'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);
    state_t      state;
    logic [15:0] cnt;
    assign cmd_ready = (state == IDLE);
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state       <= IDLE;
            cnt         <= '0;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            PADDR       <= '0;
            PWDATA      <= '0;
            PSTRB       <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_error   <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: if (cmd_valid) begin
                    PWRITE  <= cmd_write;
                    PADDR   <= cmd_addr;
                    PWDATA  <= cmd_write ? cmd_wdata : '0;
                    PSTRB   <= cmd_write ? cmd_strb : '0;
                    PSEL    <= 1'b1;
                    PENABLE <= 1'b0;
                    state   <= SETUP;
                end
                SETUP: begin
                    PENABLE <= 1'b1;
                    cnt     <= '0;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    // PREADY wins over the timeout on the final allowed cycle
                    if (PREADY) begin
                        rsp_rdata   <= PWRITE ? '0 : PRDATA;
                        rsp_error   <= PERROR;
                        rsp_timeout <= 1'b0;
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        state       <= RESP;
                    end else if (TIMEOUT != 0 && cnt == LAST) begin
                        rsp_rdata   <= '0;
                        rsp_error   <= 1'b1;
                        rsp_timeout <= 1'b1;
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        state       <= RESP;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_requester.sv
// tb_apb_requester: directed scoreboard bench for apb_requester (TIMEOUT=4)
module tb_apb_requester;
    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0;
    logic [3:0]  cmd_strb = '0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_error, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic        PSEL, PENABLE, PWRITE, PREADY, PERROR;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic [3:0]  PSTRB;
    int          wait_n = 0, wcnt = 0;
    logic        hang = 1'b0, perr = 1'b0;
    logic [31:0] rd_data = '0;
    logic [33:0] sb[$];
    int          errors = 0, checks = 0;

    apb_requester #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_error(rsp_error), .rsp_timeout(rsp_timeout),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY),
        .PERROR(PERROR)
    );

    always #5 PCLK = ~PCLK;

    // Completer: PREADY rises after wait_n low ACCESS cycles, never when hung
    assign PREADY = PSEL && PENABLE && !hang && (wcnt >= wait_n);
    assign PRDATA = rd_data;
    assign PERROR = perr;
    always @(posedge PCLK) wcnt <= (PSEL && PENABLE && !PREADY) ? wcnt + 1 : 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one command and follow it to rsp_valid; acc = expected ACCESS cycles
    task automatic start(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [31:0] er, input logic ee,
                         input logic et, input int acc);
        int c;
        c = 0;
        while (!cmd_ready && c < 50) begin @(negedge PCLK); c++; end
        chk("cmd_ready_before", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_strb = s;
        sb.push_back({er, ee, et});
        @(posedge PCLK);
        @(negedge PCLK);
        cmd_valid = 1'b0;
        chk("setup_bus", {PSEL, PENABLE, cmd_ready}, 3'b100);
        c = 1;
        while (!rsp_valid && c < 200) begin
            @(negedge PCLK);
            c++;
            if (!rsp_valid) begin
                chk("access_bus", {PSEL, PENABLE, PWRITE}, {2'b11, w});
                chk("access_paddr", PADDR, a);
                chk("access_pstrb", PSTRB, w ? s : 4'h0);
                chk("access_pwdata", PWDATA, w ? d : 32'h0);
            end
        end
        chk("latency", c, 2 + acc);
        chk("resp_bus_idle", {PSEL, PENABLE}, 2'b00);
    endtask

    // Hold the response bp cycles, then handshake and compare against the scoreboard
    task automatic respond(input int bp);
        logic [33:0] e;
        e = (sb.size() > 0) ? sb.pop_front() : 34'h0;
        for (int i = 0; i < bp; i++) begin
            chk("bp_valid", rsp_valid, 1);
            chk("bp_cmd_ready", cmd_ready, 0);
            chk("bp_psel", PSEL, 0);
            chk("bp_fields", {rsp_rdata, rsp_error, rsp_timeout}, e);
            @(negedge PCLK);
        end
        rsp_ready = 1'b1;
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_fields", {rsp_rdata, rsp_error, rsp_timeout}, e);
        @(posedge PCLK);
        @(negedge PCLK);
        rsp_ready = 1'b0;
        chk("rsp_cleared", rsp_valid, 0);
        chk("cmd_ready_after", cmd_ready, 1);
    endtask

    initial begin
        #12;
        chk("reset_bus", {PSEL, PENABLE, PWRITE, rsp_valid, rsp_error, rsp_timeout}, 6'b0);
        chk("reset_data", {PADDR, PSTRB, rsp_rdata}, 68'h0);
        chk("reset_cmd_ready", cmd_ready, 1);
        @(negedge PCLK);
        PRESETn = 1'b1;
        @(negedge PCLK);
        // Zero-wait write
        wait_n = 0; rd_data = 32'hA5A5A5A5;
        start(1'b1, 32'h4, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 1'b0, 1);
        respond(0);
        // Read with 3 wait states; strobes must be forced to zero
        wait_n = 3; rd_data = 32'h12345678;
        start(1'b0, 32'h8, 32'hFFFFFFFF, 4'hF, 32'h12345678, 1'b0, 1'b0, 4);
        respond(0);
        // Error response
        wait_n = 0; perr = 1'b1;
        start(1'b1, 32'h40, 32'h11223344, 4'h3, 32'h0, 1'b1, 1'b0, 1);
        respond(0);
        perr = 1'b0;
        // Timeout: completer never ready
        hang = 1'b1; rd_data = 32'hCAFEF00D;
        start(1'b0, 32'hC, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1, 4);
        respond(0);
        // Ready on the final allowed cycle is a normal completion
        hang = 1'b0; wait_n = 3;
        start(1'b0, 32'h10, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0, 1'b0, 4);
        respond(0);
        // Backpressure with a command queued behind the pending response
        wait_n = 1; rd_data = 32'h0BADF00D;
        start(1'b0, 32'h14, 32'h0, 4'h0, 32'h0BADF00D, 1'b0, 1'b0, 2);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h18;
        cmd_wdata = 32'h55AA55AA; cmd_strb = 4'h5;
        respond(5);
        wait_n = 0;
        start(1'b1, 32'h18, 32'h55AA55AA, 4'h5, 32'h0, 1'b0, 1'b0, 1);
        respond(0);
        // Reset in the middle of a hung read
        hang = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h1C;
        @(posedge PCLK);
        @(negedge PCLK);
        cmd_valid = 1'b0;
        @(negedge PCLK);
        @(negedge PCLK);
        chk("pre_reset_access", {PSEL, PENABLE}, 2'b11);
        #1 PRESETn = 1'b0;
        #1;
        chk("async_reset_bus", {PSEL, PENABLE, rsp_valid}, 3'b000);
        @(negedge PCLK);
        PRESETn = 1'b1;
        hang = 1'b0; wait_n = 2; rd_data = 32'h76543210;
        @(negedge PCLK);
        start(1'b0, 32'h20, 32'h0, 4'h0, 32'h76543210, 1'b0, 1'b0, 3);
        respond(0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
